// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM, one-entry
// skid buffer for responses landing during a stall, and the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    input  logic        IF_flush,
    input  logic        IF_ID_write,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_pc4,
    output logic [31:0] IF_ID_inst,
    output logic        IF_ID_valid
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DISCARD} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
    } ifid_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt, pc_plus4;
    logic [31:0] buf_inst, buf_inst_nxt;
    logic        buf_valid, buf_valid_nxt;
    ifid_t       ifid_q, ifid_nxt;

    logic resp, accept, stash, drain;

    assign pc_plus4 = pc + 32'd4;

    // accept: response goes straight into IF/ID; stash: it lands in the skid buffer
    assign resp   = (state == S_WAIT) && imem_rvalid;
    assign accept = resp && IF_ID_write && !pc_src && !IF_flush;
    assign stash  = resp && !pc_src && (!IF_ID_write || IF_flush);
    assign drain  = buf_valid && IF_ID_write && !pc_src && !IF_flush;

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        imem_addr = pc;
        unique case (state)
            S_FETCH: begin
                // a redirect this cycle would make the request stale, so hold it back
                imem_req = !buf_valid && !pc_src;
                if (imem_req)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (accept) begin
                    imem_req  = 1'b1;
                    imem_addr = pc_plus4;
                end else if (imem_rvalid) begin
                    state_nxt = S_FETCH;
                end else if (pc_src) begin
                    state_nxt = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (imem_rvalid)
                    state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
        if (!rst_n)
            imem_req = 1'b0;
    end

    always_comb begin
        pc_nxt = pc;
        if (pc_src)
            pc_nxt = branch_target & ~32'h3;
        else if (accept || drain)
            pc_nxt = pc_plus4;
    end

    always_comb begin
        buf_inst_nxt  = buf_inst;
        buf_valid_nxt = buf_valid;
        if (pc_src) begin
            buf_valid_nxt = 1'b0;
        end else if (stash) begin
            buf_inst_nxt  = imem_rdata;
            buf_valid_nxt = 1'b1;
        end else if (drain) begin
            buf_valid_nxt = 1'b0;
        end
    end

    always_comb begin
        ifid_nxt = ifid_q;
        if (pc_src || IF_flush) begin
            ifid_nxt.inst  = NOP_INST;
            ifid_nxt.valid = 1'b0;
        end else if (IF_ID_write) begin
            if (accept || drain) begin
                ifid_nxt.pc    = pc;
                ifid_nxt.pc4   = pc_plus4;
                ifid_nxt.inst  = drain ? buf_inst : imem_rdata;
                ifid_nxt.valid = 1'b1;
            end else begin
                ifid_nxt.inst  = NOP_INST;
                ifid_nxt.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_FETCH;
            pc           <= RESET_PC;
            buf_inst     <= NOP_INST;
            buf_valid    <= 1'b0;
            ifid_q.pc    <= 32'h0;
            ifid_q.pc4   <= 32'h0;
            ifid_q.inst  <= NOP_INST;
            ifid_q.valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            buf_inst  <= buf_inst_nxt;
            buf_valid <= buf_valid_nxt;
            ifid_q    <= ifid_nxt;
        end
    end

    assign IF_ID_pc    = ifid_q.pc;
    assign IF_ID_pc4   = ifid_q.pc4;
    assign IF_ID_inst  = ifid_q.inst;
    assign IF_ID_valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory model, program-order stream
// reference, directed scenarios and a randomized control run.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        pc_src = 1'b0, IF_flush = 1'b0, IF_ID_write = 1'b1;
    logic [31:0] branch_target = 32'h0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] IF_ID_pc, IF_ID_pc4, IF_ID_inst;
    logic        IF_ID_valid;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .branch_target(branch_target),
        .IF_flush(IF_flush), .IF_ID_write(IF_ID_write),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_ID_pc(IF_ID_pc), .IF_ID_pc4(IF_ID_pc4), .IF_ID_inst(IF_ID_inst),
        .IF_ID_valid(IF_ID_valid)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    // memory model: one pending request, answered lat cycles after it was issued
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_wait = 0;
    int          lat = 1;
    logic        s_req;
    logic [31:0] s_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0010_0093;
        if (a == 32'h4) return 32'h0020_0113;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
    endfunction

    // reference: the next valid IF/ID entry must be the word at exp_pc
    logic [31:0] exp_pc = 32'h0;
    int          nloads = 0;
    bit          mon_en = 1'b0;
    logic        m_act, m_src, m_flush, m_wr, p_valid;
    logic [31:0] m_tgt, p_pc, p_pc4, p_inst;

    always @(negedge clk) begin
        if (!rst_n) exp_pc = 32'h0;
        m_act = mon_en && rst_n;
        m_src = pc_src; m_flush = IF_flush; m_wr = IF_ID_write; m_tgt = branch_target;
        p_pc = IF_ID_pc; p_pc4 = IF_ID_pc4; p_inst = IF_ID_inst; p_valid = IF_ID_valid;
    end

    always @(posedge clk) begin
        #1;
        if (m_act) begin
            vectors++;
            if (m_src || m_flush) begin
                if (IF_ID_valid !== 1'b0 || IF_ID_inst !== NOP || IF_ID_pc !== p_pc) begin
                    miscompares++;
                    $display("FAIL model_bubble: valid=%b inst=%h pc=%h want valid=0 inst=%h pc=%h",
                             IF_ID_valid, IF_ID_inst, IF_ID_pc, NOP, p_pc);
                end
                if (m_src) exp_pc = m_tgt & ~32'h3;
            end else if (!m_wr) begin
                if ({IF_ID_pc, IF_ID_pc4, IF_ID_inst, IF_ID_valid} !== {p_pc, p_pc4, p_inst, p_valid}) begin
                    miscompares++;
                    $display("FAIL model_stall_hold: pc=%h inst=%h valid=%b want pc=%h inst=%h valid=%b",
                             IF_ID_pc, IF_ID_inst, IF_ID_valid, p_pc, p_inst, p_valid);
                end
            end else if (IF_ID_valid === 1'b1) begin
                if (IF_ID_pc !== exp_pc || IF_ID_pc4 !== exp_pc + 32'd4 || IF_ID_inst !== mem_word(exp_pc)) begin
                    miscompares++;
                    $display("FAIL model_stream: pc=%h pc4=%h inst=%h want pc=%h pc4=%h inst=%h",
                             IF_ID_pc, IF_ID_pc4, IF_ID_inst, exp_pc, exp_pc + 32'd4, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                nloads++;
            end else if (IF_ID_inst !== NOP || IF_ID_pc !== p_pc) begin
                miscompares++;
                $display("FAIL model_empty: inst=%h pc=%h want inst=%h pc=%h", IF_ID_inst, IF_ID_pc, NOP, p_pc);
            end
        end
    end

    // one clock cycle: drive memory response, observe request mid-cycle, return after the edge
    task automatic tick();
        if (pend && pend_wait == 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
            pend        = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pend) pend_wait--;
        end
        @(negedge clk);
        s_req  = imem_req;
        s_addr = imem_addr;
        if (s_req === 1'b1) begin
            vectors++;
            if (pend || s_addr[1:0] !== 2'b00) begin
                miscompares++;
                $display("FAIL req_protocol: addr=%h outstanding=%b want aligned with none outstanding", s_addr, pend);
            end
            pend = 1'b1; pend_addr = s_addr; pend_wait = lat;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        mon_en = 1'b0; rst_n = 1'b0; pend = 1'b0; lat = 1; imem_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++; $display("FAIL reset_req: got %b want 0", imem_req);
        end
        vectors++;
        if (IF_ID_pc !== 32'h0 || IF_ID_pc4 !== 32'h0 || IF_ID_inst !== NOP || IF_ID_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ifid: pc=%h pc4=%h inst=%h valid=%b want 0/0/%h/0", IF_ID_pc, IF_ID_pc4, IF_ID_inst, IF_ID_valid, NOP);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; mon_en = 1'b1;
    endtask

    task automatic test_basic_stream();
        tick();
        vectors++;
        if (s_req !== 1'b1 || s_addr !== 32'h0) begin
            miscompares++; $display("FAIL basic_req0: req=%b addr=%h want 1/00000000", s_req, s_addr);
        end
        tick();
        vectors++;
        if (s_req !== 1'b1 || s_addr !== 32'h4) begin
            miscompares++; $display("FAIL basic_req1: req=%b addr=%h want 1/00000004", s_req, s_addr);
        end
        vectors++;
        if (IF_ID_inst !== 32'h0010_0093 || IF_ID_pc !== 32'h0 || IF_ID_valid !== 1'b1) begin
            miscompares++; $display("FAIL basic_inst0: inst=%h pc=%h valid=%b want 00100093/0/1", IF_ID_inst, IF_ID_pc, IF_ID_valid);
        end
        tick();
        vectors++;
        if (s_req !== 1'b1 || s_addr !== 32'h8) begin
            miscompares++; $display("FAIL basic_req2: req=%b addr=%h want 1/00000008", s_req, s_addr);
        end
        vectors++;
        if (IF_ID_inst !== 32'h0020_0113 || IF_ID_pc !== 32'h4 || IF_ID_valid !== 1'b1) begin
            miscompares++; $display("FAIL basic_inst1: inst=%h pc=%h valid=%b want 00200113/4/1", IF_ID_inst, IF_ID_pc, IF_ID_valid);
        end
    endtask

    task automatic test_stall();
        IF_ID_write = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (s_req !== 1'b0 || IF_ID_pc !== 32'h4 || IF_ID_inst !== 32'h0020_0113 || IF_ID_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: req=%b pc=%h inst=%h valid=%b want 0/4/00200113/1", i, s_req, IF_ID_pc, IF_ID_inst, IF_ID_valid);
            end
        end
        IF_ID_write = 1'b1;
        tick();
        vectors++;
        if (s_req !== 1'b0 || IF_ID_pc !== 32'h8 || IF_ID_inst !== mem_word(32'h8) || IF_ID_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release: req=%b pc=%h inst=%h valid=%b want 0/8/%h/1", s_req, IF_ID_pc, IF_ID_inst, IF_ID_valid, mem_word(32'h8));
        end
    endtask

    task automatic test_latency3();
        lat = 3;
        for (int i = 0; i < 9; i++) begin
            tick();
            vectors++;
            if (s_req !== (i % 3 == 0) || IF_ID_valid !== (i > 0 && i % 3 == 0)) begin
                miscompares++;
                $display("FAIL lat3[%0d]: req=%b valid=%b want %b/%b", i, s_req, IF_ID_valid, (i % 3 == 0), (i > 0 && i % 3 == 0));
            end
        end
    endtask

    task automatic test_redirect_wait();
        tick();
        vectors++;
        if (s_req !== 1'b1 || s_addr !== 32'h18) begin
            miscompares++; $display("FAIL redir_wait_pre: req=%b addr=%h want 1/00000018", s_req, s_addr);
        end
        pc_src = 1'b1; branch_target = 32'h40;
        tick();
        pc_src = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (s_req !== 1'b0 || IF_ID_valid !== 1'b0) begin
                miscompares++; $display("FAIL redir_discard[%0d]: req=%b valid=%b want 0/0", i, s_req, IF_ID_valid);
            end
            if (i < 2) tick();
        end
        lat = 1;
        tick();
        vectors++;
        if (s_req !== 1'b1 || s_addr !== 32'h40) begin
            miscompares++; $display("FAIL redir_target_req: req=%b addr=%h want 1/00000040", s_req, s_addr);
        end
        tick();
        vectors++;
        if (IF_ID_pc !== 32'h40 || IF_ID_inst !== mem_word(32'h40) || IF_ID_valid !== 1'b1 || s_addr !== 32'h44) begin
            miscompares++;
            $display("FAIL redir_target_inst: pc=%h inst=%h valid=%b addr=%h want 40/%h/1/44", IF_ID_pc, IF_ID_inst, IF_ID_valid, s_addr, mem_word(32'h40));
        end
    endtask

    task automatic test_redirect_rvalid();
        pc_src = 1'b1; branch_target = 32'h43; IF_ID_write = 1'b0;
        tick();
        vectors++;
        if (s_req !== 1'b0 || IF_ID_valid !== 1'b0 || IF_ID_inst !== NOP) begin
            miscompares++; $display("FAIL redir_rvalid_drop: req=%b valid=%b inst=%h want 0/0/%h", s_req, IF_ID_valid, IF_ID_inst, NOP);
        end
        pc_src = 1'b0; IF_ID_write = 1'b1;
        tick();
        vectors++;
        if (s_req !== 1'b1 || s_addr !== 32'h40) begin
            miscompares++; $display("FAIL redir_rvalid_req: req=%b addr=%h want 1/00000040", s_req, s_addr);
        end
        tick();
        vectors++;
        if (IF_ID_pc !== 32'h40 || IF_ID_inst !== mem_word(32'h40) || IF_ID_valid !== 1'b1) begin
            miscompares++; $display("FAIL redir_rvalid_inst: pc=%h inst=%h valid=%b want 40/%h/1", IF_ID_pc, IF_ID_inst, IF_ID_valid, mem_word(32'h40));
        end
    endtask

    task automatic test_wrap();
        pc_src = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        pc_src = 1'b0;
        tick();
        vectors++;
        if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
            miscompares++; $display("FAIL wrap_req: req=%b addr=%h want 1/fffffffc", s_req, s_addr);
        end
        tick();
        vectors++;
        if (s_addr !== 32'h0 || IF_ID_pc !== 32'hFFFF_FFFC || IF_ID_pc4 !== 32'h0 || IF_ID_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_pc4: addr=%h pc=%h pc4=%h valid=%b want 0/fffffffc/0/1", s_addr, IF_ID_pc, IF_ID_pc4, IF_ID_valid);
        end
    endtask

    task automatic test_reset_midwait();
        lat = 3;
        tick();
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (imem_req !== 1'b0 || IF_ID_pc !== 32'h0 || IF_ID_pc4 !== 32'h0 || IF_ID_inst !== NOP || IF_ID_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: req=%b pc=%h pc4=%h inst=%h valid=%b want 0/0/0/%h/0", imem_req, IF_ID_pc, IF_ID_pc4, IF_ID_inst, IF_ID_valid, NOP);
        end
        pend = 1'b0; imem_rvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; mon_en = 1'b1; lat = 1;
        tick();
        vectors++;
        if (s_req !== 1'b1 || s_addr !== 32'h0) begin
            miscompares++; $display("FAIL post_reset_req: req=%b addr=%h want 1/00000000", s_req, s_addr);
        end
    endtask

    task automatic test_random();
        int start_loads;
        start_loads = nloads;
        for (int i = 0; i < 3000; i++) begin
            pc_src        = ($urandom_range(0, 11) == 0);
            branch_target = $urandom & 32'h0000_00FF;
            IF_flush      = ($urandom_range(0, 9) == 0);
            IF_ID_write   = ($urandom_range(0, 3) != 0);
            lat           = $urandom_range(1, 3);
            tick();
        end
        pc_src = 1'b0; IF_flush = 1'b0; IF_ID_write = 1'b1;
        vectors++;
        if (nloads - start_loads < 100) begin
            miscompares++; $display("FAIL random_progress: loads=%0d want >=100", nloads - start_loads);
        end
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_stall();
        test_latency3();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_reset_midwait();
        test_random();
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
